// File: rtl/memory_binned_paged.sv
// Paged, binned RAM with internal per-bin fill counters and a 2-cycle registered read port.
// Optional stored parity with rd_perr output: define MEMORY_BINNED_PARITY_EN.
module memory_binned_paged #(
    parameter int unsigned RAM_WIDTH = 14,
    parameter int unsigned NBINS     = 8,
    parameter int unsigned NPAGES    = 4,
    parameter int unsigned ENT_BITS  = 4,
    localparam int unsigned PB = (NPAGES > 1) ? $clog2(NPAGES) : 1,
    localparam int unsigned BB = $clog2(NBINS),
    localparam int unsigned NW = ENT_BITS + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_page,
    input  logic                         wr_en,
    input  logic [BB-1:0]                wr_bin,
    input  logic [RAM_WIDTH-1:0]         wr_data,
    output logic [PB-1:0]                wr_page,
    output logic                         wr_full,
    input  logic                         rd_en,
    input  logic [PB-1:0]                rd_page,
    input  logic [BB-1:0]                rd_bin,
    input  logic [ENT_BITS-1:0]          rd_ent,
    output logic [RAM_WIDTH-1:0]         rd_data,
    output logic                         rd_valid,
`ifdef MEMORY_BINNED_PARITY_EN
    output logic                         rd_perr,
`endif
    output logic [NPAGES*NBINS*NW-1:0]   nent_o,
    output logic [NPAGES-1:0]            ovf
);

    localparam int unsigned NCNT = NPAGES * NBINS;
    localparam int unsigned IW   = $clog2(NCNT);
    localparam int unsigned AW   = IW + ENT_BITS;
`ifdef MEMORY_BINNED_PARITY_EN
    localparam int unsigned MW   = RAM_WIDTH + 1;
`else
    localparam int unsigned MW   = RAM_WIDTH;
`endif
    localparam logic [NW-1:0] CntFull = {1'b1, {ENT_BITS{1'b0}}};

    logic [PB-1:0]    r_wr_page;
    logic [PB-1:0]    w_nxt_page;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_rd_idx;
    logic [NW-1:0]    r_nent [NCNT];
    logic [NPAGES-1:0] r_ovf;
    logic [NW-1:0]    w_cnt;
    logic             w_full;
    logic             w_clr_wr;
    logic             w_wr_ok;
    logic             w_wr_ovf;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [MW-1:0]    w_wr_word;
    logic [MW-1:0]    r_mem [NCNT << ENT_BITS];
    logic [MW-1:0]    r_ram_q;
    logic             r_rd_v1;
    logic [RAM_WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    generate
        if (NPAGES > 1) begin : g_multi
            assign w_wr_idx   = {r_wr_page, wr_bin};
            assign w_rd_idx   = {rd_page, rd_bin};
            assign w_nxt_page = r_wr_page + PB'(1);
        end else begin : g_single
            logic w_unused_rd_page;
            assign w_unused_rd_page = ^rd_page;
            assign w_wr_idx   = wr_bin;
            assign w_rd_idx   = rd_bin;
            assign w_nxt_page = '0;
        end
    endgenerate

    assign w_cnt    = r_nent[w_wr_idx];
    assign w_full   = (w_cnt == CntFull);
    // With a single page the page clear hits the bin being written, so the clear wins.
    assign w_clr_wr = (NPAGES == 1) && new_page;
    assign w_wr_ok  = wr_en && !w_full && !w_clr_wr;
    assign w_wr_ovf = wr_en && w_full && !w_clr_wr;

    assign w_wr_addr = {w_wr_idx, w_cnt[ENT_BITS-1:0]};
    assign w_rd_addr = {w_rd_idx, rd_ent};
`ifdef MEMORY_BINNED_PARITY_EN
    assign w_wr_word = {^wr_data, wr_data};
`else
    assign w_wr_word = wr_data;
`endif

    // Page clear is assigned last so it overrides a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_page <= '0;
            r_ovf     <= '0;
            for (int i = 0; i < NCNT; i++) begin
                r_nent[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_nent[w_wr_idx] <= w_cnt + NW'(1);
            end
            if (w_wr_ovf) begin
                r_ovf[r_wr_page] <= 1'b1;
            end
            if (new_page) begin
                r_wr_page         <= w_nxt_page;
                r_ovf[w_nxt_page] <= 1'b0;
                for (int i = 0; i < NCNT; i++) begin
                    if ((i / NBINS) == int'(w_nxt_page)) begin
                        r_nent[i] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_q    <= '0;
            r_rd_v1    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_v1    <= rd_en;
            r_rd_valid <= r_rd_v1;
            if (rd_en) begin
                r_ram_q <= r_mem[w_rd_addr];
            end
            if (r_rd_v1) begin
                r_rd_data <= r_ram_q[RAM_WIDTH-1:0];
            end
        end
    end

`ifdef MEMORY_BINNED_PARITY_EN
    logic r_rd_perr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_perr <= 1'b0;
        end else begin
            r_rd_perr <= r_rd_v1 && (^r_ram_q);
        end
    end
    assign rd_perr = r_rd_perr;
`endif

    always_comb begin
        nent_o = '0;
        for (int i = 0; i < NCNT; i++) begin
            nent_o[i*NW +: NW] = r_nent[i];
        end
    end

    assign wr_page  = r_wr_page;
    assign wr_full  = w_full;
    assign ovf      = r_ovf;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_memory_binned_paged.sv
// Directed bench for memory_binned_paged: a 4-page instance plus a 1-page instance for the
// same-edge clear/write case.
module tb_memory_binned_paged;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_page, wr_en, rd_en;
    logic [2:0]  wr_bin, rd_bin;
    logic [13:0] wr_data;
    logic [1:0]  wr_page, rd_page;
    logic        wr_full, rd_valid;
    logic [3:0]  rd_ent;
    logic [13:0] rd_data;
    logic [159:0] nent_o;
    logic [3:0]  ovf;

    logic        s_new_page, s_wr_en, s_wr_full, s_rd_valid;
    logic [2:0]  s_wr_bin;
    logic [13:0] s_wr_data, s_rd_data;
    logic [0:0]  s_wr_page, s_ovf;
    logic [39:0] s_nent_o;
    logic        s_rd_en = 1'b0;
    logic [0:0]  s_rd_page = 1'b0;
    logic [2:0]  s_rd_bin = 3'd0;
    logic [3:0]  s_rd_ent = 4'd0;
`ifdef MEMORY_BINNED_PARITY_EN
    logic        rd_perr, s_rd_perr;
`endif

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    memory_binned_paged dut (
        .clk(clk), .rst(rst), .new_page(new_page), .wr_en(wr_en), .wr_bin(wr_bin),
        .wr_data(wr_data), .wr_page(wr_page), .wr_full(wr_full), .rd_en(rd_en),
        .rd_page(rd_page), .rd_bin(rd_bin), .rd_ent(rd_ent), .rd_data(rd_data),
        .rd_valid(rd_valid),
`ifdef MEMORY_BINNED_PARITY_EN
        .rd_perr(rd_perr),
`endif
        .nent_o(nent_o), .ovf(ovf)
    );

    memory_binned_paged #(.NPAGES(1)) dut1 (
        .clk(clk), .rst(rst), .new_page(s_new_page), .wr_en(s_wr_en), .wr_bin(s_wr_bin),
        .wr_data(s_wr_data), .wr_page(s_wr_page), .wr_full(s_wr_full), .rd_en(s_rd_en),
        .rd_page(s_rd_page), .rd_bin(s_rd_bin), .rd_ent(s_rd_ent), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid),
`ifdef MEMORY_BINNED_PARITY_EN
        .rd_perr(s_rd_perr),
`endif
        .nent_o(s_nent_o), .ovf(s_ovf)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int unsigned nent(input int p, input int b);
        return 32'(nent_o[(p*8+b)*5 +: 5]);
    endfunction

    function automatic int unsigned s_nent(input int b);
        return 32'(s_nent_o[b*5 +: 5]);
    endfunction

    task automatic wr(input logic [2:0] b, input logic [13:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_bin = b; wr_data = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] p, input logic [2:0] b,
                      input logic [3:0] e, input int unsigned exp, input bit exp_perr);
        @(negedge clk);
        rd_en = 1'b1; rd_page = p; rd_bin = b; rd_ent = e;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid_e1"}, 32'(rd_valid), 0);
        @(negedge clk);
        check({tag, "_valid_e2"}, 32'(rd_valid), 1);
        check({tag, "_data"}, 32'(rd_data), exp);
`ifdef MEMORY_BINNED_PARITY_EN
        check({tag, "_perr"}, 32'(rd_perr), 32'(exp_perr));
`else
        if (exp_perr) $display("note: parity not built, %s perr expectation skipped", tag);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; new_page = 0; wr_en = 0; rd_en = 0;
        wr_bin = 0; rd_bin = 0; wr_data = 0; rd_page = 0; rd_ent = 0;
        s_new_page = 0; s_wr_en = 0; s_wr_bin = 0; s_wr_data = 0;
        repeat (2) @(negedge clk);
        check("rst_wr_page", 32'(wr_page), 0);
        check("rst_nent_any", 32'(|nent_o), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        // Back-to-back writes, then reads with latency checks.
        wr(3'd2, 14'h11); wr(3'd2, 14'h22); wr(3'd2, 14'h33); wr_end();
        check("b2_count", nent(0, 2), 3);
        rd("rd_e0", 2'd0, 3'd2, 4'd0, 32'h11, 1'b0);
        rd("rd_e1", 2'd0, 3'd2, 4'd1, 32'h22, 1'b0);
        rd("rd_e2", 2'd0, 3'd2, 4'd2, 32'h33, 1'b0);
`ifdef MEMORY_BINNED_PARITY_EN
        dut.r_mem[32][14] = ~dut.r_mem[32][14];
        rd("rd_perr_flip", 2'd0, 3'd2, 4'd0, 32'h11, 1'b1);
`endif

        // Saturation and overflow flag.
        for (int i = 0; i < 17; i++) wr(3'd5, 14'(256 + i));
        wr_end();
        check("sat_count", nent(0, 5), 16);
        check("sat_full", 32'(wr_full), 1);
        check("sat_ovf", 32'(ovf), 4'b0001);
        wr_bin = 3'd2;
        #1 check("b2_not_full", 32'(wr_full), 0);
        rd("rd_sat15", 2'd0, 3'd5, 4'd15, 32'h10F, 1'b0);
        rd("rd_sat0", 2'd0, 3'd5, 4'd0, 32'h100, 1'b0);

        // Page ring: page 0 counts survive until the pointer wraps back to it.
        for (int i = 0; i < 4; i++) wr(3'd1, 14'(12'h201 + i));
        wr_end();
        check("b1_count", nent(0, 1), 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) new_page = 1'b1;
            @(negedge clk) new_page = 1'b0;
            check($sformatf("np%0d_page", k), 32'(wr_page), 32'((k + 1) % 4));
            check($sformatf("np%0d_p0b1", k), nent(0, 1), (k == 3) ? 0 : 4);
            if (k == 1) begin
                wr(3'd3, 14'h077); wr_end();
                check("p2b3_count", nent(2, 3), 1);
            end
        end
        check("wrap_ovf_clr", 32'(ovf), 0);
        check("wrap_p0b5", nent(0, 5), 0);

        // Advance to page 1; single-page instance gets a plain write.
        @(negedge clk);
        new_page = 1'b1; s_wr_en = 1'b1; s_wr_bin = 3'd3; s_wr_data = 14'h55;
        @(negedge clk);
        new_page = 1'b0; s_wr_en = 1'b0;
        check("adv_page", 32'(wr_page), 1);
        check("s_plain_count", s_nent(3), 1);

        // new_page + wr_en on the same edge.
        @(negedge clk);
        new_page = 1'b1; wr_en = 1'b1; wr_bin = 3'd3; wr_data = 14'h3AB;
        s_new_page = 1'b1; s_wr_en = 1'b1; s_wr_bin = 3'd3;
        @(negedge clk);
        new_page = 1'b0; wr_en = 1'b0; s_new_page = 1'b0; s_wr_en = 1'b0;
        check("same_page", 32'(wr_page), 2);
        check("same_p1b3", nent(1, 3), 1);
        check("same_p2b3_clr", nent(2, 3), 0);
        check("s_same_count", s_nent(3), 0);
        check("s_same_ovf", 32'(s_ovf), 0);
        check("s_same_page", 32'(s_wr_page), 0);
        rd("rd_same", 2'd1, 3'd3, 4'd0, 32'h3AB, 1'b0);

        for (int i = 0; i < 17; i++) wr(3'd4, 14'(i));
        wr_end();
        check("p2_ovf", 32'(ovf), 4'b0100);

        // Asynchronous reset with a read in flight and a write pending.
        @(negedge clk);
        rd_en = 1'b1; rd_page = 2'd1; rd_bin = 3'd3; rd_ent = 4'd0;
        @(posedge clk);
        #2;
        rd_en = 1'b0; rst = 1'b1; wr_en = 1'b1; wr_bin = 3'd0; wr_data = 14'h2A;
        #1;
        check("arst_nent_any", 32'(|nent_o), 0);
        check("arst_ovf", 32'(ovf), 0);
        check("arst_page", 32'(wr_page), 0);
        check("arst_valid", 32'(rd_valid), 0);
        @(negedge clk);
        @(negedge clk);
        check("arst_valid_late", 32'(rd_valid), 0);
        check("arst_no_count", nent(0, 0), 0);
        rst = 1'b0; wr_en = 1'b0;
        check("arst_rd_data", 32'(rd_data), 0);

        wr(3'd0, 14'h2A); wr_end();
        check("post_count", nent(0, 0), 1);
        rd("rd_post", 2'd0, 3'd0, 4'd0, 32'h2A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_binned_paged.md
Name: memory_binned_paged

Overview:
- Parametrised successor to the fixed 4-page x 8-bin binned memory.
- Stores VM stubs, or any RAM_WIDTH word, in NPAGES x NBINS bins of BIN_DEPTH entries each.
- Keeps the per-bin entry counters internally, auto-increments the write slot, and advances and clears pages on a page strobe.
- Sits between a writing processing module (VMRouter) and a reading one (ME/TE), which sees the counts as a flat bus.

Parameters:
- RAM_WIDTH, 14, data word width.
- NBINS, 8, bins per page; power of 2, at least 2.
- NPAGES, 4, pages (BX ring); power of 2, at least 1.
- ENT_BITS, 4, log2 of BIN_DEPTH; BIN_DEPTH = 2**ENT_BITS entries per bin.
- Derived, not overridable: PB = clog2(NPAGES) (minimum 1), BB = clog2(NBINS), NW = ENT_BITS+1 (counter width).

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, asynchronous active-high reset.
- new_page, input, 1, strobe: advance the write page and clear its counters.
- wr_en, input, 1, write request.
- wr_bin, input, BB, target bin.
- wr_data, input, RAM_WIDTH, data to store.
- wr_page, output, PB, current write page.
- wr_full, output, 1, combinational: bin wr_bin of wr_page is full.
- rd_en, input, 1, read request.
- rd_page, input, PB, read page.
- rd_bin, input, BB, read bin.
- rd_ent, input, ENT_BITS, entry within the bin.
- rd_data, output, RAM_WIDTH, read data.
- rd_valid, output, 1, rd_data is valid.
- nent_o, output, NPAGES*NBINS*NW, flat count bus; field index p*NBINS+b occupies bits [idx*NW +: NW].
- ovf, output, NPAGES, sticky per-page "write dropped" flag.

Behaviour:
- Storage is a block RAM of NPAGES*NBINS*BIN_DEPTH words. Address = {page, bin, entry}.
- RAM contents are not reset. Counters, flags and pointers are reset.
- Reset values, applied asynchronously: wr_page=0; all nent counters=0; ovf=0; rd_valid=0; rd_data=0; read pipeline cleared.
- Write (single cycle):
  - On wr_en with count c = nent[wr_page][wr_bin] < BIN_DEPTH: write RAM at {wr_page, wr_bin, c[ENT_BITS-1:0]} and set the counter to c+1 on the same edge.
  - nent_o reflects the new count the cycle after the edge.
  - When c == BIN_DEPTH: no RAM write, counter holds, ovf[wr_page] is set.
- Back-to-back writes to the same bin on consecutive cycles land in consecutive entries with no bubble.
- new_page:
  - On the edge: wr_page <= wr_page+1, wrapping mod NPAGES.
  - All NBINS counters of the new page clear to 0, and ovf[new page] clears.
  - Other pages are untouched, so the reader keeps its counts for older pages.
- new_page together with wr_en in the same cycle: the write targets the pre-advance page.
  - Exception, NPAGES==1: the clear takes priority, the write is dropped, the counter ends at 0 and ovf is not set.
- Read, fixed 2-cycle latency:
  - Cycle 0 samples rd_en and the address. The RAM output register is loaded at edge 1. rd_data/rd_valid are registered at edge 2.
  - rd_valid is rd_en delayed by 2.
  - When rd_valid=0, rd_data holds its last value.
- Reads are not gated by count. Reading an entry at or above nent returns stale RAM contents; the consumer must bound reads by nent_o.
- Read/write to the same address in the same cycle is read-first: the old data is returned.
- Reset asserted mid-operation: the in-flight read is discarded (rd_valid=0), and any write in that cycle is not counted.
- Counters are saturating, NW bits; they never wrap.

Optional Feature:
- Macro MEMORY_BINNED_PARITY_EN.
- When defined:
  - The RAM stores RAM_WIDTH+1 bits; the extra bit is the even parity of wr_data.
  - An extra output port rd_perr (1 bit) is registered alongside rd_data, with the same latency. It is 1 when the stored parity mismatches the recomputed parity, is qualified by rd_valid, and resets to 0.
- When undefined: no parity bit is stored and the rd_perr port does not exist.

Test Plan:
- Reset, then 3 writes to bin 2 (data 0x11, 0x22, 0x33), then reads of entries 0..2 -> nent field p0/b2 = 3; rd_data = 0x11, 0x22, 0x33, each with rd_valid exactly 2 cycles after its rd_en.
- 17 writes to bin 5 with ENT_BITS=4 -> count saturates at 16, entry 15 holds the 16th datum, ovf[0]=1, wr_full=1.
- Fill page 0 bin 1 with count 4, pulse new_page 4 times with NPAGES=4 -> wr_page goes 1,2,3,0 and page 0 counters clear to 0 on the final pulse; page 0 counts stay intact until then.
- new_page and wr_en on the same edge (NPAGES=4, wr_page=1) -> the datum lands in page 1; wr_page becomes 2 and page 2 counts are 0. With NPAGES=1 the write is dropped and the count is 0.
- Assert rst asynchronously between a rd_en and its rd_valid cycle -> rd_valid stays 0, and all nent and ovf are 0 immediately without waiting for a clock edge.
- With MEMORY_BINNED_PARITY_EN: flip the stored parity bit via a force, then read -> rd_perr=1 with rd_valid. A normal read gives rd_perr=0.
